shift_barrelpipe_rright: RTL and testbench

SHIFT_BARRELPIPE_RRIGHT -- requirements
Module: shift_barrelpipe_rright

---
 rtl/shift_barrelpipe_rright_if.sv | 38 +++
 rtl/shift_barrelpipe_rright.sv | 73 +++++++
 tb/tb_shift_barrelpipe_rright.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/shift_barrelpipe_rright_if.sv
// Purpose: handshake bundle for the pipelined rotate-right block (input word/amount, output result).
// Latency: none, this is wiring only.
// Backpressure: a_retry flows back to the producer and b_retry comes from the consumer.
interface shift_barrelpipe_rright_if #(
    parameter int Bits = 64
);
    localparam int S = $clog2(Bits);

    logic            a_valid;
    logic            a_retry;
    logic [Bits-1:0] a;
    logic [S-1:0]    sh;
    logic            b_valid;
    logic            b_retry;
    logic [Bits-1:0] b;

    // Producer/consumer side, as seen by whoever drives the block.
    modport master (
        output a_valid,
        output a,
        output sh,
        output b_retry,
        input  a_retry,
        input  b_valid,
        input  b
    );

    // Block side.
    modport slave (
        input  a_valid,
        input  a,
        input  sh,
        input  b_retry,
        output a_retry,
        output b_valid,
        output b
    );
endinterface

// File: rtl/shift_barrelpipe_rright.sv
// Purpose: rotate a Bits-wide word right by sh using log2(Bits) registered barrel stages.
// Latency: S = log2(Bits) register stages; a word offered in cycle c is on b in cycle c+S.
// Backpressure: whole pipe stalls when b_valid && b_retry; a_retry = !advance, no bubble squeeze.
module shift_barrelpipe_rright #(
    parameter int Bits = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    shift_barrelpipe_rright_if.slave   io
);
    localparam int S = $clog2(Bits);

    // Stage k holds data already rotated by the low k+1 sh bits, plus the
    // remaining sh bits shifted down so the next stage always tests bit 0.
    logic [Bits-1:0] data_q [S];
    logic [Bits-1:0] data_d [S];
    logic            vld_q  [S];
    logic            vld_d  [S];
    logic [S-1:0]    sh_q   [S];
    logic [S-1:0]    sh_d   [S];
    logic            adv;

    // The last stage has no later consumer of its sh bits (they are always 0).
    logic            sh_tail_unused;
    assign sh_tail_unused = ^sh_q[S-1];

    // Rotate right by a fixed power-of-two amount n (0 < n < Bits).
    function automatic logic [Bits-1:0] rotr(input logic [Bits-1:0] x, input int n);
        return (x >> n) | (x << (Bits - n));
    endfunction

    // Next-state for every stage: everything moves together on adv, else holds.
    always_comb begin
        adv = !vld_q[S-1] || !io.b_retry;
        for (int k = 0; k < S; k++) begin
            data_d[k] = data_q[k];
            vld_d[k]  = vld_q[k];
            sh_d[k]   = sh_q[k];
        end
        if (adv) begin
            // Without a transfer a_valid is 0 here, so a bubble enters stage 0.
            vld_d[0]  = io.a_valid;
            data_d[0] = io.sh[0] ? rotr(io.a, 1) : io.a;
            sh_d[0]   = io.sh >> 1;
            for (int k = 1; k < S; k++) begin
                vld_d[k]  = vld_q[k-1];
                data_d[k] = sh_q[k-1][0] ? rotr(data_q[k-1], 1 << k) : data_q[k-1];
                sh_d[k]   = sh_q[k-1] >> 1;
            end
        end
    end

    // Stage registers; reset clears valid, data and sh so nothing stale survives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < S; k++) begin
                data_q[k] <= '0;
                vld_q[k]  <= 1'b0;
                sh_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < S; k++) begin
                data_q[k] <= data_d[k];
                vld_q[k]  <= vld_d[k];
                sh_q[k]   <= sh_d[k];
            end
        end
    end

    assign io.a_retry = !adv;
    assign io.b_valid = vld_q[S-1];
    assign io.b       = data_q[S-1];
endmodule

// File: tb/tb_shift_barrelpipe_rright.sv
module tb_shift_barrelpipe_rright;
    localparam int W = 8;
    localparam int N_RAND = 10000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    shift_barrelpipe_rright_if #(.Bits(W)) bus ();

    shift_barrelpipe_rright #(.Bits(W)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus.slave)
    );

    int tests = 0;
    int fails = 0;
    int n_in  = 0;
    int n_out = 0;
    logic [W-1:0] exp_q [$];
    logic [W-1:0] mon_exp;
    logic [W-1:0] held;
    int n_rand;
    int guard;

    // Reference: rotate right as a slice of the word concatenated with itself.
    function automatic logic [W-1:0] ref_rotr(input logic [W-1:0] x, input int s);
        logic [2*W-1:0] dbl;
        dbl = {x, x} >> s;
        return dbl[W-1:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one word; called just after a rising edge, returns just after the accepting edge.
    task automatic send(input logic [W-1:0] d, input logic [2:0] s);
        int g;
        g = 0;
        bus.a_valid = 1'b1;
        bus.a       = d;
        bus.sh      = s;
        forever begin
            @(negedge clk);
            if (!bus.a_retry) begin
                exp_q.push_back(ref_rotr(d, int'(s)));
                n_in++;
                break;
            end
            g++;
            if (g > 200) begin
                tests++;
                fails++;
                $display("FAIL send_timeout: a_retry stuck at %0b, required 0 within 200 cycles", bus.a_retry);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        bus.a_valid = 1'b0;
    endtask

    // Scoreboard monitor: every output transfer must match the oldest outstanding word.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.b_valid === 1'b1 && bus.b_retry === 1'b0) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got b=%0h, required no output", bus.b);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("scoreboard_b", 32'(bus.b), 32'(mon_exp));
                    n_out++;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, required finish within 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.a_valid = 1'b0;
        bus.a       = '0;
        bus.sh      = '0;
        bus.b_retry = 1'b0;
        reset       = 1'b1;

        // Reset state, checked before any clock edge.
        #2;
        check("rst_b_valid", 32'(bus.b_valid), 0);
        check("rst_b", 32'(bus.b), 0);
        check("rst_a_retry", 32'(bus.a_retry), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("post_rst_a_retry", 32'(bus.a_retry), 0);

        // Single word: result three cycles after the cycle it is offered, then gone.
        send(8'h81, 3'd1);
        repeat (2) begin
            @(negedge clk);
            check("single_early_b_valid", 32'(bus.b_valid), 0);
        end
        @(negedge clk);
        check("single_b_valid", 32'(bus.b_valid), 1);
        check("single_b", 32'(bus.b), 32'h0C0);
        @(negedge clk);
        check("single_after_b_valid", 32'(bus.b_valid), 0);
        @(posedge clk);
        #1;

        // Back-to-back words come out on consecutive cycles in order.
        send(8'h01, 3'd7);
        send(8'hA5, 3'd0);
        send(8'h0F, 3'd4);
        @(negedge clk);
        check("b2b_0_valid", 32'(bus.b_valid), 1);
        check("b2b_0_b", 32'(bus.b), 32'h02);
        @(negedge clk);
        check("b2b_1_valid", 32'(bus.b_valid), 1);
        check("b2b_1_b", 32'(bus.b), 32'hA5);
        @(negedge clk);
        check("b2b_2_valid", 32'(bus.b_valid), 1);
        check("b2b_2_b", 32'(bus.b), 32'hF0);
        @(negedge clk);
        check("b2b_after_valid", 32'(bus.b_valid), 0);
        @(posedge clk);
        #1;

        // Fill the pipe against a stalled consumer, hold five cycles, then drain.
        bus.b_retry = 1'b1;
        send(8'h3C, 3'd2);
        send(8'h99, 3'd5);
        send(8'h7E, 3'd3);
        held = ref_rotr(8'h3C, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_a_retry", 32'(bus.a_retry), 1);
            check("stall_b_valid", 32'(bus.b_valid), 1);
            check("stall_b_hold", 32'(bus.b), 32'(held));
        end
        @(posedge clk);
        #1;
        bus.b_retry = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("stall_drained", exp_q.size(), 0);

        // Reset with two words in flight: outputs clear at once, nothing stale later.
        bus.b_retry = 1'b1;
        send(8'hC3, 3'd6);
        send(8'h5A, 3'd1);
        @(posedge clk);
        #1;
        check("inflight_b_valid", 32'(bus.b_valid), 1);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_b_valid", 32'(bus.b_valid), 0);
        check("midrst_b", 32'(bus.b), 0);
        check("midrst_a_retry", 32'(bus.a_retry), 0);
        n_in -= exp_q.size();
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.b_retry = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // Randomised traffic against the reference rotate.
        n_rand = 0;
        guard  = 0;
        while (n_rand < N_RAND && guard < 60000) begin
            bus.a_valid = ($urandom_range(0, 3) != 0);
            bus.a       = W'($urandom);
            bus.sh      = 3'($urandom);
            bus.b_retry = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (bus.a_valid && !bus.a_retry) begin
                exp_q.push_back(ref_rotr(bus.a, int'(bus.sh)));
                n_in++;
                n_rand++;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        check("rand_all_sent", n_rand, N_RAND);
        bus.a_valid = 1'b0;
        bus.b_retry = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("final_drain_empty", exp_q.size(), 0);
        check("count_in_eq_out", n_out, n_in);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
